serial_frame_tx: RTL and testbench

Parallel-in, serial-out transmitter that feeds the N-bit serial-in shift register stage. It accepts an N-bit word over a valid/ready handshake. It then drives the downstream register's data input, shift strobe and active-low clear, so that after one frame the downstream Q equals the accepted word. The block runs on the system clock and generates a slow, glitch-free shift strobe with a programmable half-period.

---
 rtl/serial_frame_tx_pkg.sv | 18 +
 rtl/serial_frame_tx_if.sv | 16 +
 rtl/serial_frame_tx_strobe_timer.sv | 27 ++
 rtl/serial_frame_tx.sv | 103 ++++++++++
 tb/tb_serial_frame_tx.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake plus serial link to the downstream shift register.
interface serial_frame_tx_if #(parameter int N = 4);
  logic [N-1:0] DIN;
  logic         LOAD;
  logic         READY;
  logic         BUSY;
  logic         DONE;
  logic         SDATA;
  logic         SSHIFT;
  logic         SCLRN;

  modport master (output DIN, LOAD,
                  input  READY, BUSY, DONE, SDATA, SSHIFT, SCLRN);
  modport slave  (input  DIN, LOAD,
                  output READY, BUSY, DONE, SDATA, SSHIFT, SCLRN);
endinterface

// File: rtl/serial_frame_tx_strobe_timer.sv
// Half-period counter: one-cycle tick every DIV cycles, held at 0 while cleared.
module strobe_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign tick_o = !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter driving a downstream shift register.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 2
) (
  input  logic               CLK,
  input  logic               RST,
  serial_frame_tx_if.slave   bus
);
  localparam int BW = clog2(N + 1);

  if (DIV < 2) begin : g_div_chk
    $error("serial_frame_tx: DIV must be >= 2");
  end
  if (N < 2) begin : g_n_chk
    $error("serial_frame_tx: N must be >= 2");
  end

  state_t        state_q;
  logic [N-2:0]  sreg_q;     // bits still to send; MSB goes straight to SDATA
  logic [BW-1:0] bitcnt_q;
  logic          ready_q, busy_q, done_q, sdata_q, sshift_q, sclrn_q;
  logic          tick, tmr_clr;

  assign tmr_clr = (state_q == IDLE) || (state_q == FIN);

  strobe_timer #(.DIV(DIV)) u_tmr (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (tmr_clr),
    .tick_o(tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sshift_q <= 1'b0;
      sclrn_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          sshift_q <= 1'b0;
          sclrn_q  <= 1'b1;
          if (bus.LOAD && ready_q) begin
            sreg_q   <= bus.DIN[N-2:0];
            bitcnt_q <= BW'(N);
            sdata_q  <= bus.DIN[N-1];
            sclrn_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= LOW;
          end
        end
        LOW: begin
          // clear pulse lasts only the first LOW cycle of a frame
          sclrn_q <= 1'b1;
          if (tick) begin
            sshift_q <= 1'b1;
            state_q  <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sshift_q <= 1'b0;
            bitcnt_q <= (bitcnt_q != '0) ? bitcnt_q - BW'(1) : '0;
            if (bitcnt_q > BW'(1)) begin
              sdata_q <= sreg_q[N-2];
              sreg_q  <= sreg_q << 1;
              state_q <= LOW;
            end else begin
              sdata_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.READY  = ready_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.SDATA  = sdata_q;
  assign bus.SSHIFT = sshift_q;
  assign bus.SCLRN  = sclrn_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench: two transmitter configurations, each feeding a model of the downstream shift register.
module tb_serial_frame_tx;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  serial_frame_tx_if #(.N(4)) a_if();
  serial_frame_tx_if #(.N(8)) b_if();

  serial_frame_tx #(.N(4), .DIV(2)) dut_a (.CLK(CLK), .RST(RST), .bus(a_if));
  serial_frame_tx #(.N(8), .DIV(3)) dut_b (.CLK(CLK), .RST(RST), .bus(b_if));

  // downstream shift registers: clear on CLR low, shift A in on SHIFT rise
  logic [3:0] qa = '0;
  logic [7:0] qb = '0;
  always @(posedge a_if.SSHIFT or negedge a_if.SCLRN)
    if (!a_if.SCLRN) qa <= '0; else qa <= {qa[2:0], a_if.SDATA};
  always @(posedge b_if.SSHIFT or negedge b_if.SCLRN)
    if (!b_if.SCLRN) qb <= '0; else qb <= {qb[6:0], b_if.SDATA};

  int rises_a = 0, rises_b = 0;
  always @(posedge a_if.SSHIFT) rises_a++;
  always @(posedge b_if.SSHIFT) rises_b++;

  int cur = 0;
  logic [5:0] obs;   // {SDATA, SSHIFT, SCLRN, DONE, READY, BUSY}
  always_comb begin
    obs = {a_if.SDATA, a_if.SSHIFT, a_if.SCLRN, a_if.DONE, a_if.READY, a_if.BUSY};
    if (cur != 0) obs = {b_if.SDATA, b_if.SSHIFT, b_if.SCLRN, b_if.DONE, b_if.READY, b_if.BUSY};
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic [7:0] d, input logic l);
    if (s == 0) begin a_if.DIN = d[3:0]; a_if.LOAD = l; end
    else        begin b_if.DIN = d;      b_if.LOAD = l; end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // mode 0: single LOAD pulse; 1: LOAD/DIN=FF flood in cycles 3-12; 2: LOAD held, DIN -> nxt
  task automatic frame_check(input int s, input logic [7:0] din, input int mode,
                             input logic [7:0] nxt, input logic [7:0] expq);
    int n, d, last, r0, bi;
    bit got;
    logic [5:0] e;
    logic [7:0] q;
    n = (s != 0) ? 8 : 4;
    d = (s != 0) ? 3 : 2;
    last = 2 * d * n + 1;
    cur = s;
    #0;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      if (obs[1]) got = 1'b1;
      else step();
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_wait sel=%0d got READY=0 want READY=1 within 200 cycles", s);
    end
    drive(s, din, 1'b1);
    r0 = (s != 0) ? rises_b : rises_a;
    step();
    if (mode == 2) drive(s, nxt, 1'b1); else drive(s, din, 1'b0);
    for (int k = 0; k <= last; k++) begin
      if (k < last - 1) begin
        bi = k / (2 * d);
        e = {din[n-1-bi], ((k % (2 * d)) >= d), (k != 0), 1'b0, 1'b0, 1'b1};
      end else if (k == last - 1) e = 6'b001101;
      else                        e = 6'b001010;
      chk($sformatf("wave sel=%0d din=%h k=%0d", s, din, k), 32'(obs), 32'(e));
      if (k < last) begin
        if (mode == 1) drive(s, 8'hFF, (k >= 3 && k <= 12));
        step();
      end
    end
    q = (s != 0) ? qb : {4'h0, qa};
    chk($sformatf("q sel=%0d din=%h", s, din), 32'(q), 32'(expq));
    chk($sformatf("rises sel=%0d din=%h", s, din),
        32'(((s != 0) ? rises_b : rises_a) - r0), 32'(n));
  endtask

  typedef struct {
    int         sel;
    logic [7:0] din;
    int         mode;
    logic [7:0] nxt;
    logic [7:0] expq;
  } vec_t;

  vec_t vecs[5];
  int r_before;

  initial begin
    vecs[0] = '{0, 8'h0B, 0, 8'h00, 8'h0B};
    vecs[1] = '{0, 8'h0A, 2, 8'h05, 8'h0A};
    vecs[2] = '{0, 8'h05, 0, 8'h00, 8'h05};
    vecs[3] = '{0, 8'h03, 1, 8'h00, 8'h03};
    vecs[4] = '{1, 8'h96, 0, 8'h00, 8'h96};

    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    #1;
    cur = 0; #0;
    chk("reset_a", 32'(obs), 32'd0);
    cur = 1; #0;
    chk("reset_b", 32'(obs), 32'd0);
    chk("reset_qa", 32'(qa), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // idle after reset: only SCLRN and READY high
    step();
    for (int i = 0; i < 20; i++) begin
      cur = 0; #0;
      chk($sformatf("idle_a c=%0d", i), 32'(obs), 32'(6'b001010));
      step();
    end
    cur = 1; #0;
    chk("idle_b", 32'(obs), 32'(6'b001010));

    for (int v = 0; v < 5; v++)
      frame_check(vecs[v].sel, vecs[v].din, vecs[v].mode, vecs[v].nxt, vecs[v].expq);

    // reset in cycle 9 of a 4'hC frame
    cur = 0;
    drive(0, 8'h0C, 1'b1);
    step();
    drive(0, 8'h0C, 1'b0);
    repeat (9) step();
    r_before = rises_a;
    chk("pre_rst_qa", 32'(qa), 32'h3);
    RST = 1'b1;
    #1;
    chk("rst_mid_out", 32'(obs), 32'd0);
    chk("rst_mid_qa", 32'(qa), 32'd0);
    repeat (2) begin
      step();
      chk("rst_hold_done", 32'(a_if.DONE), 32'd0);
    end
    RST = 1'b0;
    step();
    chk("rst_release", 32'(obs), 32'(6'b001010));
    chk("rst_no_rise", 32'(rises_a - r_before), 32'd0);
    frame_check(0, 8'h06, 0, 8'h00, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
